// File: rtl/bsg_manycore_vcache_dma_arbiter.sv
// Shares one vcache DMA channel (packet, writeback, fill) among num_cache_p bsg_cache DMA ports.
// Define BSG_MANYCORE_VCACHE_DMA_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bsg_manycore_vcache_dma_arbiter #(
  parameter  int num_cache_p      = 2,
  parameter  int addr_width_p     = 32,
  parameter  int mask_width_p     = 8,
  parameter  int dma_data_width_p = 32,
  parameter  int burst_len_p      = 4,
  parameter  int max_out_p        = 4,
  localparam int pkt_width_lp     = 1 + addr_width_p + mask_width_p
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,

  input  logic [num_cache_p-1:0][pkt_width_lp-1:0]     cache_dma_pkt_i,
  input  logic [num_cache_p-1:0]                       cache_dma_pkt_v_i,
  output logic [num_cache_p-1:0]                       cache_dma_pkt_yumi_o,

  output logic [num_cache_p-1:0][dma_data_width_p-1:0] cache_dma_data_o,
  output logic [num_cache_p-1:0]                       cache_dma_data_v_o,
  input  logic [num_cache_p-1:0]                       cache_dma_data_ready_and_i,

  input  logic [num_cache_p-1:0][dma_data_width_p-1:0] cache_dma_data_i,
  input  logic [num_cache_p-1:0]                       cache_dma_data_v_i,
  output logic [num_cache_p-1:0]                       cache_dma_data_yumi_o,

  output logic [pkt_width_lp-1:0]                      dma_pkt_o,
  output logic                                         dma_pkt_v_o,
  input  logic                                         dma_pkt_yumi_i,

  input  logic [dma_data_width_p-1:0]                  dma_data_i,
  input  logic                                         dma_data_v_i,
  output logic                                         dma_data_ready_and_o,

  output logic [dma_data_width_p-1:0]                  dma_data_o,
  output logic                                         dma_data_v_o,
  input  logic                                         dma_data_yumi_i
);

  localparam int tag_width_lp = (num_cache_p > 1) ? $clog2(num_cache_p) : 1;
  localparam int cnt_width_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int ptr_width_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;
  localparam int occ_width_lp = $clog2(max_out_p + 1);

  localparam logic [cnt_width_lp-1:0] last_beat_lp  = cnt_width_lp'(burst_len_p - 1);
  localparam logic [ptr_width_lp-1:0] last_slot_lp  = ptr_width_lp'(max_out_p - 1);
  localparam logic [occ_width_lp-1:0] full_occ_lp   = occ_width_lp'(max_out_p);
  localparam logic [tag_width_lp-1:0] last_cache_lp = tag_width_lp'(num_cache_p - 1);

  typedef enum logic {ARB, WDATA} state_e;

  state_e                  state_r, state_n;
  logic [tag_width_lp-1:0] wr_owner_r;
  logic [cnt_width_lp-1:0] wr_cnt_r, rd_cnt_r;
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [occ_width_lp-1:0] occ_r;
  logic [tag_width_lp-1:0] tag_mem [max_out_p];

  logic [num_cache_p-1:0]  cand;
  logic                    grant_v;
  logic [tag_width_lp-1:0] winner;
  logic                    winner_is_write;
  logic                    pkt_fire, push, pop, wr_load, wr_beat, fill_fire;
  logic                    fifo_full, fifo_empty;
  logic [tag_width_lp-1:0] head;

  assign fifo_full  = (occ_r == full_occ_lp);
  assign fifo_empty = (occ_r == '0);
  assign head       = tag_mem[rd_ptr_r];

`ifdef BSG_MANYCORE_VCACHE_DMA_ARB_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    cand    = '0;
    grant_v = 1'b0;
    winner  = '0;
    for (int i = 0; i < num_cache_p; i++)
      cand[i] = cache_dma_pkt_v_i[i] & (cache_dma_pkt_i[i][pkt_width_lp-1] | ~fifo_full);
    for (int i = num_cache_p - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_v = 1'b1;
        winner  = tag_width_lp'(i);
      end
    end
  end
`else
  logic [tag_width_lp-1:0] rr_ptr_r;
  logic [tag_width_lp-1:0] rr_idx;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    cand    = '0;
    grant_v = 1'b0;
    winner  = '0;
    rr_idx  = '0;
    for (int i = 0; i < num_cache_p; i++)
      cand[i] = cache_dma_pkt_v_i[i] & (cache_dma_pkt_i[i][pkt_width_lp-1] | ~fifo_full);
    // Scan from the farthest offset down so the nearest candidate at/after rr_ptr_r wins.
    for (int i = num_cache_p - 1; i >= 0; i--) begin
      rr_idx = tag_width_lp'((int'(rr_ptr_r) + i) % num_cache_p);
      if (cand[rr_idx]) begin
        grant_v = 1'b1;
        winner  = rr_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      rr_ptr_r <= '0;
    else if (pkt_fire)
      rr_ptr_r <= (winner == last_cache_lp) ? '0 : winner + 1'b1;
  end
`endif

  assign winner_is_write = cache_dma_pkt_i[winner][pkt_width_lp-1];

  // Packet / writeback FSM; reset_n_i gates every handshake so nothing is offered during reset.
  always_comb begin
    state_n               = state_r;
    dma_pkt_o             = cache_dma_pkt_i[winner];
    dma_pkt_v_o           = 1'b0;
    cache_dma_pkt_yumi_o  = '0;
    dma_data_o            = cache_dma_data_i[wr_owner_r];
    dma_data_v_o          = 1'b0;
    cache_dma_data_yumi_o = '0;
    pkt_fire              = 1'b0;
    push                  = 1'b0;
    wr_load               = 1'b0;
    wr_beat               = 1'b0;
    unique case (state_r)
      ARB: begin
        dma_pkt_v_o = grant_v & reset_n_i;
        pkt_fire    = grant_v & reset_n_i & dma_pkt_yumi_i;
        if (pkt_fire) begin
          cache_dma_pkt_yumi_o[winner] = 1'b1;
          if (winner_is_write) begin
            wr_load = 1'b1;
            state_n = WDATA;
          end else begin
            push = 1'b1;
          end
        end
      end
      WDATA: begin
        dma_data_v_o = cache_dma_data_v_i[wr_owner_r] & reset_n_i;
        if (reset_n_i & dma_data_yumi_i) begin
          cache_dma_data_yumi_o[wr_owner_r] = 1'b1;
          wr_beat = 1'b1;
          if (wr_cnt_r == last_beat_lp) state_n = ARB;
        end
      end
      default: ;
    endcase
  end

  // Fill path: data fans out to every cache, only the valid is steered by the head tag.
  always_comb begin
    cache_dma_data_o     = '0;
    cache_dma_data_v_o   = '0;
    dma_data_ready_and_o = 1'b0;
    for (int i = 0; i < num_cache_p; i++) cache_dma_data_o[i] = dma_data_i;
    if (!fifo_empty && reset_n_i) begin
      cache_dma_data_v_o[head] = dma_data_v_i;
      dma_data_ready_and_o     = cache_dma_data_ready_and_i[head];
    end
  end

  assign fill_fire = dma_data_v_i & dma_data_ready_and_o;
  assign pop       = fill_fire & (rd_cnt_r == last_beat_lp);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= ARB;
      wr_owner_r <= '0;
      wr_cnt_r   <= '0;
      rd_cnt_r   <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      occ_r      <= '0;
    end else begin
      state_r <= state_n;
      if (wr_load) begin
        wr_owner_r <= winner;
        wr_cnt_r   <= '0;
      end else if (wr_beat) begin
        wr_cnt_r <= wr_cnt_r + 1'b1;
      end
      if (fill_fire) rd_cnt_r <= pop ? '0 : rd_cnt_r + 1'b1;
      if (push) wr_ptr_r <= (wr_ptr_r == last_slot_lp) ? '0 : wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= (rd_ptr_r == last_slot_lp) ? '0 : rd_ptr_r + 1'b1;
      if (push && !pop)      occ_r <= occ_r + 1'b1;
      else if (pop && !push) occ_r <= occ_r - 1'b1;
    end
  end

  // NOTE: tag storage is not reset; occupancy gates every read, so stale entries are never observed.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_r] <= winner;
  end

endmodule

// File: tb/tb_bsg_manycore_vcache_dma_arbiter.sv
// Directed bench for bsg_manycore_vcache_dma_arbiter: 2 caches, burst of 4, 4 outstanding reads.
module tb_bsg_manycore_vcache_dma_arbiter;

  localparam int N  = 2;
  localparam int A  = 8;
  localparam int M  = 4;
  localparam int D  = 16;
  localparam int B  = 4;
  localparam int MO = 4;
  localparam int PW = 1 + A + M;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic [N-1:0][PW-1:0] cache_dma_pkt_i;
  logic [N-1:0]         cache_dma_pkt_v_i, cache_dma_pkt_yumi_o;
  logic [N-1:0][D-1:0]  cache_dma_data_o;
  logic [N-1:0]         cache_dma_data_v_o, cache_dma_data_ready_and_i;
  logic [N-1:0][D-1:0]  cache_dma_data_i;
  logic [N-1:0]         cache_dma_data_v_i, cache_dma_data_yumi_o;
  logic [PW-1:0]        dma_pkt_o;
  logic                 dma_pkt_v_o, dma_pkt_yumi_i;
  logic [D-1:0]         dma_data_i;
  logic                 dma_data_v_i, dma_data_ready_and_o;
  logic [D-1:0]         dma_data_o;
  logic                 dma_data_v_o, dma_data_yumi_i;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_manycore_vcache_dma_arbiter #(
    .num_cache_p(N), .addr_width_p(A), .mask_width_p(M),
    .dma_data_width_p(D), .burst_len_p(B), .max_out_p(MO)
  ) dut (
    .clk_i                      (clk_i),
    .reset_n_i                  (reset_n_i),
    .cache_dma_pkt_i            (cache_dma_pkt_i),
    .cache_dma_pkt_v_i          (cache_dma_pkt_v_i),
    .cache_dma_pkt_yumi_o       (cache_dma_pkt_yumi_o),
    .cache_dma_data_o           (cache_dma_data_o),
    .cache_dma_data_v_o         (cache_dma_data_v_o),
    .cache_dma_data_ready_and_i (cache_dma_data_ready_and_i),
    .cache_dma_data_i           (cache_dma_data_i),
    .cache_dma_data_v_i         (cache_dma_data_v_i),
    .cache_dma_data_yumi_o      (cache_dma_data_yumi_o),
    .dma_pkt_o                  (dma_pkt_o),
    .dma_pkt_v_o                (dma_pkt_v_o),
    .dma_pkt_yumi_i             (dma_pkt_yumi_i),
    .dma_data_i                 (dma_data_i),
    .dma_data_v_i               (dma_data_v_i),
    .dma_data_ready_and_o       (dma_data_ready_and_o),
    .dma_data_o                 (dma_data_o),
    .dma_data_v_o               (dma_data_v_o),
    .dma_data_yumi_i            (dma_data_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [PW-1:0] mk_pkt(input logic w, input logic [A-1:0] a, input logic [M-1:0] m);
    return {w, a, m};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cache_dma_pkt_i            = '0;
    cache_dma_pkt_v_i          = '0;
    cache_dma_data_ready_and_i = 2'b11;
    cache_dma_data_i           = '0;
    cache_dma_data_v_i         = '0;
    dma_pkt_yumi_i             = 1'b0;
    dma_data_i                 = '0;
    dma_data_v_i               = 1'b0;
    dma_data_yumi_i            = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    idle();
    reset_n_i          = 1'b0;
    cache_dma_pkt_i[0] = mk_pkt(1'b0, 8'h01, 4'h1);
    cache_dma_pkt_i[1] = mk_pkt(1'b1, 8'h02, 4'h2);
    cache_dma_pkt_v_i  = 2'b11;
    cache_dma_data_v_i = 2'b11;
    dma_pkt_yumi_i     = 1'b1;
    dma_data_v_i       = 1'b1;
    dma_data_yumi_i    = 1'b1;
    #2;
    for (int c = 0; c < 3; c++) begin
      obs = {dma_pkt_v_o, cache_dma_pkt_yumi_o, dma_data_v_o, cache_dma_data_yumi_o,
             cache_dma_data_v_o, dma_data_ready_and_o};
      n_checks++;
      if (obs !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 000000000", c, obs);
      end
      tick();
    end
    idle();
    reset_n_i    = 1'b1;
    dma_data_v_i = 1'b1;
    #1;
    n_checks++;
    if ({dma_data_ready_and_o, cache_dma_data_v_o, dma_pkt_v_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_empty: got ready=%b v=%b pkt_v=%b expected all 0",
               dma_data_ready_and_o, cache_dma_data_v_o, dma_pkt_v_o);
    end
  endtask

  task automatic test_round_robin();
    int         exp_tag [MO];
    int         w;
    logic [1:0] ey;
    logic [PW-1:0] pk [N];
    pk[0] = mk_pkt(1'b0, 8'h10, 4'h1);
    pk[1] = mk_pkt(1'b0, 8'h20, 4'h2);
    for (int k = 0; k < MO; k++) begin
      tick();
      idle();
      cache_dma_pkt_i[0] = pk[0];
      cache_dma_pkt_i[1] = pk[1];
      cache_dma_pkt_v_i  = 2'b11;
      dma_pkt_yumi_i     = 1'b1;
      #1;
`ifdef BSG_MANYCORE_VCACHE_DMA_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = k % 2;
`endif
      exp_tag[k] = w;
      ey = 2'b01 << w;
      n_checks++;
      if ({dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o} !== {1'b1, pk[w], ey}) begin
        n_fail++;
        $display("FAIL rr_grant %0d: got v=%b pkt=%h yumi=%b expected v=1 pkt=%h yumi=%b",
                 k, dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, pk[w], ey);
      end
    end
    tick();
    #1;
    n_checks++;
    if ({dma_pkt_v_o, cache_dma_pkt_yumi_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_fifo_full_blocks: got v=%b yumi=%b expected 0 00", dma_pkt_v_o, cache_dma_pkt_yumi_o);
    end
    for (int b = 0; b < MO * B; b++) begin
      tick();
      idle();
      dma_data_v_i = 1'b1;
      dma_data_i   = 16'hA000 + 16'(b);
      #1;
      ey = 2'b01 << exp_tag[b / B];
      n_checks++;
      if ({cache_dma_data_v_o, dma_data_ready_and_o, cache_dma_data_o[exp_tag[b / B]]} !==
          {ey, 1'b1, 16'hA000 + 16'(b)}) begin
        n_fail++;
        $display("FAIL rr_fill beat %0d: got v=%b rdy=%b data=%h expected v=%b rdy=1 data=%h",
                 b, cache_dma_data_v_o, dma_data_ready_and_o, cache_dma_data_o[exp_tag[b / B]],
                 ey, 16'hA000 + 16'(b));
      end
    end
    tick();
    #1;
    n_checks++;
    if ({dma_data_ready_and_o, cache_dma_data_v_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_fill_drained: got rdy=%b v=%b expected 0 00", dma_data_ready_and_o, cache_dma_data_v_o);
    end
  endtask

  task automatic test_write_lock();
    logic [5:0]    ypat = 6'b111010;  // per-cycle yumi, LSB first: 0,1,0,1,1,1
    logic [PW-1:0] pk0, pk1;
    int            nb = 0;
    pk0 = mk_pkt(1'b1, 8'h30, 4'hF);
    pk1 = mk_pkt(1'b0, 8'h40, 4'h4);
    tick();
    idle();
    cache_dma_pkt_i[0] = pk0;
    cache_dma_pkt_i[1] = pk1;
    cache_dma_pkt_v_i  = 2'b11;
    dma_pkt_yumi_i     = 1'b1;
    #1;
    n_checks++;
    if ({dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o} !== {1'b1, pk0, 2'b01}) begin
      n_fail++;
      $display("FAIL wr_grant: got v=%b pkt=%h yumi=%b expected v=1 pkt=%h yumi=01",
               dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, pk0);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      cache_dma_pkt_v_i   = 2'b10;
      cache_dma_data_v_i  = 2'b01;
      cache_dma_data_i[0] = 16'hB000 + 16'(nb);
      cache_dma_data_i[1] = 16'hDEAD;
      dma_data_yumi_i     = ypat[c];
      #1;
      n_checks++;
      if ({dma_pkt_v_o, cache_dma_pkt_yumi_o, dma_data_v_o, dma_data_o, cache_dma_data_yumi_o} !==
          {3'b000, 1'b1, 16'hB000 + 16'(nb), 1'b0, ypat[c]}) begin
        n_fail++;
        $display("FAIL wr_beat cycle %0d: got pkt_v=%b pyumi=%b v=%b data=%h dyumi=%b expected 0 00 1 %h 0%b",
                 c, dma_pkt_v_o, cache_dma_pkt_yumi_o, dma_data_v_o, dma_data_o, cache_dma_data_yumi_o,
                 16'hB000 + 16'(nb), ypat[c]);
      end
      if (ypat[c]) nb++;
    end
    tick();
    cache_dma_data_v_i = '0;
    dma_data_yumi_i    = 1'b0;
    #1;
    n_checks++;
    if ({dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, dma_data_v_o} !== {1'b1, pk1, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_release: got v=%b pkt=%h yumi=%b dv=%b expected v=1 pkt=%h yumi=10 dv=0",
               dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, dma_data_v_o, pk1);
    end
  endtask

  task automatic test_fill_stall();
    logic [6:0] rpat = 7'b1110001;  // cache 1 ready per cycle, LSB first: 1,0,0,0,1,1,1
    int         nb = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      idle();
      dma_data_v_i                  = 1'b1;
      dma_data_i                    = 16'hC000 + 16'(nb);
      cache_dma_data_ready_and_i[1] = rpat[c];
      #1;
      n_checks++;
      if ({cache_dma_data_v_o, dma_data_ready_and_o, cache_dma_data_o[1]} !==
          {2'b10, rpat[c], 16'hC000 + 16'(nb)}) begin
        n_fail++;
        $display("FAIL fill_stall cycle %0d: got v=%b rdy=%b data=%h expected v=10 rdy=%b data=%h",
                 c, cache_dma_data_v_o, dma_data_ready_and_o, cache_dma_data_o[1], rpat[c],
                 16'hC000 + 16'(nb));
      end
      if (rpat[c]) nb++;
    end
    tick();
    #1;
    n_checks++;
    if ({dma_data_ready_and_o, cache_dma_data_v_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL fill_stall_count: got rdy=%b v=%b expected 0 00 after 4 beats",
               dma_data_ready_and_o, cache_dma_data_v_o);
    end
  endtask

  task automatic test_fifo_full();
    logic [PW-1:0] pk0, pk1;
    for (int k = 0; k < MO; k++) begin
      tick();
      idle();
      pk0                = mk_pkt(1'b0, 8'h50 + 8'(k), 4'h5);
      cache_dma_pkt_i[0] = pk0;
      cache_dma_pkt_v_i  = 2'b01;
      dma_pkt_yumi_i     = 1'b1;
      #1;
      n_checks++;
      if ({dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o} !== {1'b1, pk0, 2'b01}) begin
        n_fail++;
        $display("FAIL full_fill_up %0d: got v=%b pkt=%h yumi=%b expected v=1 pkt=%h yumi=01",
                 k, dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, pk0);
      end
    end
    pk0 = mk_pkt(1'b0, 8'h60, 4'h6);
    pk1 = mk_pkt(1'b1, 8'h70, 4'h7);
    tick();
    cache_dma_pkt_i[0] = pk0;
    cache_dma_pkt_i[1] = pk1;
    cache_dma_pkt_v_i  = 2'b11;
    #1;
    n_checks++;
    if ({dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o} !== {1'b1, pk1, 2'b10}) begin
      n_fail++;
      $display("FAIL full_write_passes: got v=%b pkt=%h yumi=%b expected v=1 pkt=%h yumi=10",
               dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, pk1);
    end
    for (int k = 0; k < B; k++) begin
      tick();
      cache_dma_pkt_v_i   = 2'b01;
      cache_dma_data_v_i  = 2'b10;
      cache_dma_data_i[1] = 16'hE000 + 16'(k);
      dma_data_yumi_i     = 1'b1;
      #1;
      n_checks++;
      if ({dma_data_v_o, dma_data_o, cache_dma_data_yumi_o, cache_dma_pkt_yumi_o} !==
          {1'b1, 16'hE000 + 16'(k), 2'b10, 2'b00}) begin
        n_fail++;
        $display("FAIL full_wb beat %0d: got v=%b data=%h dyumi=%b pyumi=%b expected 1 %h 10 00",
                 k, dma_data_v_o, dma_data_o, cache_dma_data_yumi_o, cache_dma_pkt_yumi_o,
                 16'hE000 + 16'(k));
      end
    end
    // Fill the head read; the last beat pops while the held read must still be refused.
    for (int b = 0; b < B; b++) begin
      tick();
      cache_dma_data_v_i = '0;
      dma_data_yumi_i    = 1'b0;
      dma_data_v_i       = 1'b1;
      #1;
      n_checks++;
      if ({dma_pkt_v_o, cache_dma_pkt_yumi_o, cache_dma_data_v_o} !== 5'b00001) begin
        n_fail++;
        $display("FAIL full_hold beat %0d: got pkt_v=%b pyumi=%b fill_v=%b expected 0 00 01",
                 b, dma_pkt_v_o, cache_dma_pkt_yumi_o, cache_dma_data_v_o);
      end
    end
    tick();
    dma_data_v_i = 1'b0;
    #1;
    n_checks++;
    if ({dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o} !== {1'b1, pk0, 2'b01}) begin
      n_fail++;
      $display("FAIL full_after_pop: got v=%b pkt=%h yumi=%b expected v=1 pkt=%h yumi=01",
               dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, pk0);
    end
    for (int b = 0; b < MO * B; b++) begin
      tick();
      idle();
      dma_data_v_i = 1'b1;
      #1;
      n_checks++;
      if ({cache_dma_data_v_o, dma_data_ready_and_o} !== 3'b011) begin
        n_fail++;
        $display("FAIL full_drain beat %0d: got v=%b rdy=%b expected 01 1",
                 b, cache_dma_data_v_o, dma_data_ready_and_o);
      end
    end
    tick();
    #1;
    n_checks++;
    if (dma_data_ready_and_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained: got rdy=%b expected 0", dma_data_ready_and_o);
    end
  endtask

  task automatic test_reset_midburst();
    logic [PW-1:0] pk0, pk1;
    logic [8:0]    obs;
    pk0 = mk_pkt(1'b1, 8'h80, 4'h8);
    pk1 = mk_pkt(1'b0, 8'h90, 4'h9);
    tick();
    idle();
    cache_dma_pkt_i[0] = pk0;
    cache_dma_pkt_v_i  = 2'b01;
    dma_pkt_yumi_i     = 1'b1;
    #1;
    n_checks++;
    if (cache_dma_pkt_yumi_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_grant: got yumi=%b expected 01", cache_dma_pkt_yumi_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      cache_dma_pkt_v_i   = 2'b00;
      cache_dma_data_v_i  = 2'b01;
      cache_dma_data_i[0] = 16'hF000 + 16'(c);
      dma_data_yumi_i     = (c < 2);
      #1;
      n_checks++;
      if ({dma_data_v_o, dma_data_o} !== {1'b1, 16'hF000 + 16'(c)}) begin
        n_fail++;
        $display("FAIL rstmid_beat %0d: got v=%b data=%h expected 1 %h",
                 c, dma_data_v_o, dma_data_o, 16'hF000 + 16'(c));
      end
    end
    cache_dma_pkt_i[1] = pk1;
    cache_dma_pkt_v_i  = 2'b10;
    dma_data_v_i       = 1'b1;
    reset_n_i          = 1'b0;
    #1;
    obs = {dma_pkt_v_o, cache_dma_pkt_yumi_o, dma_data_v_o, cache_dma_data_yumi_o,
           cache_dma_data_v_o, dma_data_ready_and_o};
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got %b expected 000000000", obs);
    end
    tick();
    reset_n_i          = 1'b1;
    cache_dma_data_v_i = '0;
    dma_data_yumi_i    = 1'b0;
    #1;
    n_checks++;
    if ({dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, dma_data_v_o, dma_data_ready_and_o} !==
        {1'b1, pk1, 2'b10, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got v=%b pkt=%h yumi=%b dv=%b rdy=%b expected v=1 pkt=%h yumi=10 dv=0 rdy=0",
               dma_pkt_v_o, dma_pkt_o, cache_dma_pkt_yumi_o, dma_data_v_o, dma_data_ready_and_o, pk1);
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_lock();
    test_fill_stall();
    test_fifo_full();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
